// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: word-organised storage with byte-lane writes, a fixed
// number of wait states per OKAY data phase and a two-cycle ERROR response.
module ahb_sram_slave #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 256,
    parameter int REGION_BITS = 12,
    parameter int WAIT        = 1
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic             HSELx,
    input  logic [WIDTH-1:0] HADDR,
    input  logic             HWRITE,
    input  logic [2:0]       HSIZE,
    input  logic [1:0]       HTRANS,
    input  logic [2:0]       HBURST,
    input  logic [3:0]       HPROT,
    input  logic             HMASTLOCK,
    input  logic             HREADY,
    input  logic [WIDTH-1:0] HWDATA,
    output logic [WIDTH-1:0] HRDATA,
    output logic             HREADYOUT,
    output logic             HRESP
);

    // state | meaning
    // IDLE  | no data phase, or a zero-wait OKAY data phase when pend is set
    // WAIT  | OKAY data phase; stalls while cnt != 0, completes at cnt == 0
    // ERR1  | first ERROR cycle (HREADYOUT low)
    // ERR2  | second ERROR cycle (HREADYOUT high)
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ERR1 = 2'd2;
    localparam logic [1:0] ST_ERR2 = 2'd3;

    localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT);

    logic [1:0]       state, state_nxt;
    logic [3:0]       cnt, cnt_nxt;
    logic             pend, pend_nxt;
    logic [AW-1:0]    idx_q;
    logic [3:0]       be_q, be_nxt;
    logic             wr_q;
    logic [WIDTH-1:0] mem [DEPTH];

    logic        accept, can_take, take, addr_err, final_dp;
    logic [31:0] offset;
    logic        unused_ok;

    assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], HADDR[WIDTH-1:REGION_BITS]};

    assign accept   = HSELx & HREADY & HTRANS[1];
    assign offset   = 32'(HADDR[REGION_BITS-1:0]);
    assign addr_err = (offset >= 32'(DEPTH * 4)) || (HSIZE > 3'd2) ||
                      ((HSIZE == 3'd1) && HADDR[0]) ||
                      ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));

    // A new address phase is only taken while our own data phase is not stalling.
    assign can_take = (state == ST_IDLE) || (state == ST_ERR2) ||
                      ((state == ST_WAIT) && (cnt == 4'd0));
    assign take     = accept & can_take;
    assign final_dp = pend && ((state == ST_IDLE) || ((state == ST_WAIT) && (cnt == 4'd0)));

    always_comb begin
        be_nxt = 4'b1111;
        case (HSIZE)
            3'd0:    be_nxt = 4'b0001 << HADDR[1:0];
            3'd1:    be_nxt = HADDR[1] ? 4'b1100 : 4'b0011;
            default: be_nxt = 4'b1111;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pend_nxt  = pend;
        case (state)
            ST_WAIT: begin
                if (cnt != 4'd0) cnt_nxt = cnt - 4'd1;
                else             state_nxt = ST_IDLE;
            end
            ST_ERR1: state_nxt = ST_ERR2;
            default: state_nxt = ST_IDLE;
        endcase
        if (final_dp) pend_nxt = 1'b0;
        if (take) begin
            pend_nxt = ~addr_err;
            if (addr_err) begin
                state_nxt = ST_ERR1;
                cnt_nxt   = 4'd0;
            end else if (WAIT_LOAD != 4'd0) begin
                state_nxt = ST_WAIT;
                cnt_nxt   = WAIT_LOAD;
            end else begin
                state_nxt = ST_IDLE;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
            pend  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pend  <= pend_nxt;
        end
    end

    always_ff @(posedge HCLK) begin
        if (take) begin
            idx_q <= HADDR[AW+1:2];
            be_q  <= be_nxt;
            wr_q  <= HWRITE;
        end
    end

    // Storage has no reset; a write pending at a reset edge is dropped.
    always_ff @(posedge HCLK) begin
        if (!HRESET && final_dp && wr_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

    assign HREADYOUT = ~((state == ST_ERR1) || ((state == ST_WAIT) && (cnt != 4'd0)));
    assign HRESP     = (state == ST_ERR1) || (state == ST_ERR2);
    assign HRDATA    = (final_dp && !wr_q) ? mem[idx_q] : '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench: three slave instances (WAIT = 0, 1, 3) share the bus inputs
// and are addressed one at a time through their own HSELx.
module tb_ahb_sram_slave;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic [31:0] HADDR = '0;
    logic        HWRITE = 1'b0;
    logic [2:0]  HSIZE = 3'd2;
    logic [1:0]  HTRANS = 2'd0;
    logic [2:0]  HBURST = 3'd0;
    logic [3:0]  HPROT = 4'd0;
    logic        HMASTLOCK = 1'b0;
    logic [31:0] HWDATA = '0;

    logic        hsel   [3];
    logic        hro    [3];
    logic        hresp  [3];
    logic [31:0] hrdata [3];

    int total = 0;
    int bad   = 0;

    always #5 HCLK = ~HCLK;

    ahb_sram_slave #(.WAIT(0)) u_w0 (
        .HCLK(HCLK), .HRESET(HRESET), .HSELx(hsel[0]), .HADDR(HADDR), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HTRANS(HTRANS), .HBURST(HBURST), .HPROT(HPROT),
        .HMASTLOCK(HMASTLOCK), .HREADY(hro[0]), .HWDATA(HWDATA),
        .HRDATA(hrdata[0]), .HREADYOUT(hro[0]), .HRESP(hresp[0]));

    ahb_sram_slave #(.WAIT(1)) u_w1 (
        .HCLK(HCLK), .HRESET(HRESET), .HSELx(hsel[1]), .HADDR(HADDR), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HTRANS(HTRANS), .HBURST(HBURST), .HPROT(HPROT),
        .HMASTLOCK(HMASTLOCK), .HREADY(hro[1]), .HWDATA(HWDATA),
        .HRDATA(hrdata[1]), .HREADYOUT(hro[1]), .HRESP(hresp[1]));

    ahb_sram_slave #(.WAIT(3)) u_w3 (
        .HCLK(HCLK), .HRESET(HRESET), .HSELx(hsel[2]), .HADDR(HADDR), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HTRANS(HTRANS), .HBURST(HBURST), .HPROT(HPROT),
        .HMASTLOCK(HMASTLOCK), .HREADY(hro[2]), .HWDATA(HWDATA),
        .HRDATA(hrdata[2]), .HREADYOUT(hro[2]), .HRESP(hresp[2]));

    // One non-pipelined transfer on instance k; starts and ends 1 time unit after a rising edge.
    task automatic xfer(input int k, input logic wr, input logic [31:0] addr,
                        input logic [2:0] size, input logic [31:0] wdata,
                        output int ncyc, output logic ro_first, output logic resp_first,
                        output logic resp_last, output logic [31:0] rd_first,
                        output logic [31:0] rd_last);
        logic done;
        hsel[k] = 1'b1; HTRANS = 2'd2; HADDR = addr; HWRITE = wr; HSIZE = size;
        @(posedge HCLK); #1;
        hsel[k] = 1'b0; HTRANS = 2'd0; HWDATA = wdata;
        ncyc = 0; done = 1'b0;
        ro_first = 1'bx; resp_first = 1'bx; resp_last = 1'bx; rd_first = 'x; rd_last = 'x;
        while (!done && ncyc < 20) begin
            @(negedge HCLK);
            if (ncyc == 0) begin
                ro_first = hro[k]; resp_first = hresp[k]; rd_first = hrdata[k];
            end
            ncyc++;
            resp_last = hresp[k]; rd_last = hrdata[k];
            if (hro[k] === 1'b1) done = 1'b1;
        end
        if (!done) ncyc = -1;
        @(posedge HCLK); #1;
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        repeat (3) @(posedge HCLK);
        #1 HRESET = 1'b0;
        @(negedge HCLK);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (hro[k] !== 1'b1 || hresp[k] !== 1'b0 || hrdata[k] !== 32'h0) begin
                bad++;
                $display("FAIL reset_outputs inst=%0d got ro=%b resp=%b rd=%h want ro=1 resp=0 rd=0",
                         k, hro[k], hresp[k], hrdata[k]);
            end
        end
        @(posedge HCLK); #1;
    endtask

    task automatic test_wait1();
        int n; logic rf, sf, sl; logic [31:0] df, dl;
        xfer(1, 1'b1, 32'h010, 3'd2, 32'hDEADBEEF, n, rf, sf, sl, df, dl);
        total++;
        if (n !== 2 || rf !== 1'b0 || sl !== 1'b0) begin
            bad++;
            $display("FAIL w1_write got cycles=%0d ro_first=%b resp=%b want 2 0 0", n, rf, sl);
        end
        xfer(1, 1'b0, 32'h010, 3'd2, 32'h0, n, rf, sf, sl, df, dl);
        total++;
        if (n !== 2 || rf !== 1'b0 || sl !== 1'b0) begin
            bad++;
            $display("FAIL w1_read_timing got cycles=%0d ro_first=%b resp=%b want 2 0 0", n, rf, sl);
        end
        total++;
        if (dl !== 32'hDEADBEEF || df !== 32'h0) begin
            bad++;
            $display("FAIL w1_read_data got first=%h last=%h want 00000000 deadbeef", df, dl);
        end
    endtask

    task automatic test_zero_wait();
        int n; logic rf, sf, sl; logic [31:0] df, dl;
        xfer(0, 1'b1, 32'h020, 3'd2, 32'h11223344, n, rf, sf, sl, df, dl);
        total++;
        if (n !== 1 || rf !== 1'b1) begin
            bad++;
            $display("FAIL w0_word_write got cycles=%0d ro_first=%b want 1 1", n, rf);
        end
        xfer(0, 1'b1, 32'h022, 3'd0, 32'h00AA0000, n, rf, sf, sl, df, dl);
        total++;
        if (n !== 1 || rf !== 1'b1) begin
            bad++;
            $display("FAIL w0_byte_write got cycles=%0d ro_first=%b want 1 1", n, rf);
        end
        xfer(0, 1'b0, 32'h020, 3'd2, 32'h0, n, rf, sf, sl, df, dl);
        total++;
        if (n !== 1 || dl !== 32'h11AA3344) begin
            bad++;
            $display("FAIL w0_byte_merge got cycles=%0d rd=%h want 1 11aa3344", n, dl);
        end
    endtask

    task automatic test_halfword_lanes();
        int n; logic rf, sf, sl; logic [31:0] df, dl;
        xfer(0, 1'b1, 32'h024, 3'd2, 32'h55667788, n, rf, sf, sl, df, dl);
        xfer(0, 1'b1, 32'h026, 3'd1, 32'hCAFE0000, n, rf, sf, sl, df, dl);
        xfer(0, 1'b0, 32'h024, 3'd1, 32'h0, n, rf, sf, sl, df, dl);
        total++;
        if (dl !== 32'hCAFE7788) begin
            bad++;
            $display("FAIL half_upper got rd=%h want cafe7788", dl);
        end
        xfer(0, 1'b1, 32'h1024, 3'd1, 32'h00001234, n, rf, sf, sl, df, dl);
        xfer(0, 1'b0, 32'h026, 3'd0, 32'h0, n, rf, sf, sl, df, dl);
        total++;
        if (dl !== 32'hCAFE1234 || sl !== 1'b0) begin
            bad++;
            $display("FAIL half_lower_alias got rd=%h resp=%b want cafe1234 0", dl, sl);
        end
    endtask

    task automatic test_error_range();
        int n; logic rf, sf, sl; logic [31:0] df, dl;
        xfer(1, 1'b0, 32'h400, 3'd2, 32'h0, n, rf, sf, sl, df, dl);
        total++;
        if (n !== 2 || rf !== 1'b0 || sf !== 1'b1 || sl !== 1'b1) begin
            bad++;
            $display("FAIL err_range got cycles=%0d ro_first=%b resp_first=%b resp_last=%b want 2 0 1 1",
                     n, rf, sf, sl);
        end
        total++;
        if (df !== 32'h0 || dl !== 32'h0) begin
            bad++;
            $display("FAIL err_rdata got first=%h last=%h want 0 0", df, dl);
        end
        xfer(1, 1'b0, 32'h010, 3'd2, 32'h0, n, rf, sf, sl, df, dl);
        total++;
        if (n !== 2 || sl !== 1'b0 || dl !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL err_recover got cycles=%0d resp=%b rd=%h want 2 0 deadbeef", n, sl, dl);
        end
    endtask

    task automatic test_error_align();
        int n; logic rf, sf, sl; logic [31:0] df, dl;
        xfer(1, 1'b1, 32'h030, 3'd2, 32'h0BADF00D, n, rf, sf, sl, df, dl);
        xfer(1, 1'b1, 32'h031, 3'd1, 32'hFFFFFFFF, n, rf, sf, sl, df, dl);
        total++;
        if (n !== 2 || rf !== 1'b0 || sf !== 1'b1 || sl !== 1'b1) begin
            bad++;
            $display("FAIL err_half_misalign got cycles=%0d ro_first=%b resp=%b/%b want 2 0 1/1", n, rf, sf, sl);
        end
        xfer(1, 1'b1, 32'h030, 3'd3, 32'hFFFFFFFF, n, rf, sf, sl, df, dl);
        total++;
        if (n !== 2 || rf !== 1'b0 || sf !== 1'b1 || sl !== 1'b1) begin
            bad++;
            $display("FAIL err_size3 got cycles=%0d ro_first=%b resp=%b/%b want 2 0 1/1", n, rf, sf, sl);
        end
        xfer(1, 1'b1, 32'h032, 3'd2, 32'hFFFFFFFF, n, rf, sf, sl, df, dl);
        total++;
        if (n !== 2 || sf !== 1'b1) begin
            bad++;
            $display("FAIL err_word_misalign got cycles=%0d resp=%b want 2 1", n, sf);
        end
        xfer(1, 1'b0, 32'h030, 3'd2, 32'h0, n, rf, sf, sl, df, dl);
        total++;
        if (dl !== 32'h0BADF00D) begin
            bad++;
            $display("FAIL err_no_write got rd=%h want 0badf00d", dl);
        end
    endtask

    task automatic test_back_to_back();
        // WAIT=1: write 0x050 then read 0x050 whose address phase overlaps the write's final cycle.
        hsel[1] = 1'b1; HTRANS = 2'd2; HADDR = 32'h050; HWRITE = 1'b1; HSIZE = 3'd2;
        @(posedge HCLK); #1;
        HTRANS = 2'd3; HWRITE = 1'b0; HWDATA = 32'hA5A5A5A5;
        @(negedge HCLK);
        total++;
        if (hro[1] !== 1'b0) begin
            bad++; $display("FAIL b2b_w1_stall got ro=%b want 0", hro[1]);
        end
        @(posedge HCLK); #1;
        @(negedge HCLK);
        total++;
        if (hro[1] !== 1'b1) begin
            bad++; $display("FAIL b2b_w1_wfinal got ro=%b want 1", hro[1]);
        end
        @(posedge HCLK); #1;
        hsel[1] = 1'b0; HTRANS = 2'd0; HWDATA = 32'h0;
        @(negedge HCLK);
        total++;
        if (hro[1] !== 1'b0 || hrdata[1] !== 32'h0) begin
            bad++; $display("FAIL b2b_w1_rstall got ro=%b rd=%h want 0 0", hro[1], hrdata[1]);
        end
        @(posedge HCLK); #1;
        @(negedge HCLK);
        total++;
        if (hro[1] !== 1'b1 || hrdata[1] !== 32'hA5A5A5A5) begin
            bad++; $display("FAIL b2b_w1_read got ro=%b rd=%h want 1 a5a5a5a5", hro[1], hrdata[1]);
        end
        @(posedge HCLK); #1;
        // WAIT=0: same-word write then read, fully pipelined.
        hsel[0] = 1'b1; HTRANS = 2'd2; HADDR = 32'h060; HWRITE = 1'b1; HSIZE = 3'd2;
        @(posedge HCLK); #1;
        HWRITE = 1'b0; HWDATA = 32'h01020304;
        @(negedge HCLK);
        total++;
        if (hro[0] !== 1'b1 || hrdata[0] !== 32'h0) begin
            bad++; $display("FAIL b2b_w0_wfinal got ro=%b rd=%h want 1 0", hro[0], hrdata[0]);
        end
        @(posedge HCLK); #1;
        hsel[0] = 1'b0; HTRANS = 2'd0; HWDATA = 32'h0;
        @(negedge HCLK);
        total++;
        if (hro[0] !== 1'b1 || hrdata[0] !== 32'h01020304) begin
            bad++; $display("FAIL b2b_w0_read got ro=%b rd=%h want 1 01020304", hro[0], hrdata[0]);
        end
        @(posedge HCLK); #1;
    endtask

    task automatic test_idle_busy();
        int n; logic rf, sf, sl; logic [31:0] df, dl;
        logic [1:0] tr [3];
        logic       sl_en [3];
        tr[0] = 2'd1; tr[1] = 2'd0; tr[2] = 2'd2;
        sl_en[0] = 1'b1; sl_en[1] = 1'b1; sl_en[2] = 1'b0;
        HADDR = 32'h010; HWRITE = 1'b1; HSIZE = 3'd2; HWDATA = 32'hFFFFFFFF;
        for (int p = 0; p < 3; p++) begin
            hsel[1] = sl_en[p]; HTRANS = tr[p];
            for (int c = 0; c < 2; c++) begin
                @(negedge HCLK);
                total++;
                if (hro[1] !== 1'b1 || hresp[1] !== 1'b0) begin
                    bad++;
                    $display("FAIL idle_busy pattern=%0d got ro=%b resp=%b want 1 0", p, hro[1], hresp[1]);
                end
                @(posedge HCLK); #1;
            end
        end
        hsel[1] = 1'b0; HTRANS = 2'd0;
        @(posedge HCLK); #1;
        xfer(1, 1'b0, 32'h010, 3'd2, 32'h0, n, rf, sf, sl, df, dl);
        total++;
        if (dl !== 32'hDEADBEEF) begin
            bad++; $display("FAIL idle_busy_storage got rd=%h want deadbeef", dl);
        end
    endtask

    task automatic test_reset_abort();
        int n; logic rf, sf, sl; logic [31:0] df, dl;
        xfer(2, 1'b1, 32'h040, 3'd2, 32'h12345678, n, rf, sf, sl, df, dl);
        total++;
        if (n !== 4 || rf !== 1'b0) begin
            bad++; $display("FAIL w3_write_cycles got cycles=%0d ro_first=%b want 4 0", n, rf);
        end
        hsel[2] = 1'b1; HTRANS = 2'd2; HADDR = 32'h040; HWRITE = 1'b1; HSIZE = 3'd2;
        @(posedge HCLK); #1;
        hsel[2] = 1'b0; HTRANS = 2'd0; HWDATA = 32'h87654321;
        @(posedge HCLK); #1;
        HRESET = 1'b1;
        @(negedge HCLK);
        total++;
        if (hro[2] !== 1'b0) begin
            bad++; $display("FAIL rst_abort_stall got ro=%b want 0", hro[2]);
        end
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        @(negedge HCLK);
        total++;
        if (hro[2] !== 1'b1 || hresp[2] !== 1'b0 || hrdata[2] !== 32'h0) begin
            bad++;
            $display("FAIL rst_abort_outputs got ro=%b resp=%b rd=%h want 1 0 0", hro[2], hresp[2], hrdata[2]);
        end
        @(posedge HCLK); #1;
        xfer(2, 1'b0, 32'h040, 3'd2, 32'h0, n, rf, sf, sl, df, dl);
        total++;
        if (n !== 4 || dl !== 32'h12345678) begin
            bad++; $display("FAIL rst_abort_old got cycles=%0d rd=%h want 4 12345678", n, dl);
        end
        xfer(1, 1'b0, 32'h010, 3'd2, 32'h0, n, rf, sf, sl, df, dl);
        total++;
        if (dl !== 32'hDEADBEEF) begin
            bad++; $display("FAIL rst_keeps_storage got rd=%h want deadbeef", dl);
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) hsel[k] = 1'b0;
        test_reset();
        test_wait1();
        test_zero_wait();
        test_halfword_lanes();
        test_error_range();
        test_error_align();
        test_back_to_back();
        test_idle_busy();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
